// File: rtl/sound_mixer.sv
// Mixes CHANNELS volume-scaled signed voices into one 12-bit offset-binary sample per
// frame and sequences the DAC serializer's load/en controls for one SPI frame per sample.
module sound_mixer #(
    parameter int CHANNELS   = 4,
    parameter int SAMPLE_DIV = 1024,
    parameter int FRAME_BITS = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CHANNELS*8-1:0]   voice_data,
    input  logic [CHANNELS*4-1:0]   voice_vol,
    input  logic                    mute,
    output logic                    sample_strobe,
    output logic [11:0]             total_sound,
    output logic                    load,
    output logic                    en,
    output logic                    busy
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    typedef enum logic [2:0] {IDLE, ACCUM, CLIP, LOAD, SHIFT} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic signed [14:0]      acc_q, acc_d;
    logic [CHANNELS*8-1:0]   snap_data_q, snap_data_d;
    logic [CHANNELS*4-1:0]   snap_vol_q, snap_vol_d;
    logic [11:0]             total_q, total_d;
    logic                    load_q, load_d;
    logic                    en_q, en_d;
    logic                    busy_q, busy_d;

    logic signed [7:0]       cur_sample;
    logic [3:0]              cur_vol;
    logic signed [11:0]      cur_prod;

    function automatic logic signed [11:0] scale(input logic signed [7:0] s, input logic [3:0] v);
        logic signed [12:0] p;
        p = s * $signed({1'b0, v});
        return p[11:0];
    endfunction

    // Clamp to the signed 12-bit range, then flip the MSB into offset binary.
    function automatic logic [11:0] sat_offset(input logic signed [14:0] a);
        if (a > 15'sd2047)
            return 12'hFFF;
        else if (a < -15'sd2048)
            return 12'h000;
        else
            return {~a[11], a[10:0]};
    endfunction

    always_comb begin
        cur_sample = '0;
        cur_vol    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_q == CH_W'(i)) begin
                cur_sample = snap_data_q[i*8 +: 8];
                cur_vol    = snap_vol_q[i*4 +: 4];
            end
        end
        cur_prod = scale(cur_sample, cur_vol);
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        bit_d       = bit_q;
        acc_d       = acc_q;
        snap_data_d = snap_data_q;
        snap_vol_d  = snap_vol_q;
        total_d     = total_q;
        cnt_d       = (cnt_q == CNT_W'(SAMPLE_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (cnt_q == '0) begin
                    snap_data_d = voice_data;
                    snap_vol_d  = voice_vol;
                    acc_d       = '0;
                    ch_d        = '0;
                    state_d     = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + $signed({{3{cur_prod[11]}}, cur_prod});
                if (ch_q == CH_W'(CHANNELS - 1))
                    state_d = CLIP;
                else
                    ch_d = ch_q + CH_W'(1);
            end
            CLIP: begin
                total_d = mute ? 12'h800 : sat_offset(acc_q);
                state_d = LOAD;
            end
            LOAD: begin
                bit_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (bit_q == BIT_W'(FRAME_BITS - 1))
                    state_d = IDLE;
                else
                    bit_d = bit_q + BIT_W'(1);
            end
            default: state_d = IDLE;
        endcase

        load_d = (state_d == LOAD);
        en_d   = (state_d == SHIFT);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ch_q    <= '0;
            bit_q   <= '0;
            acc_q   <= '0;
            total_q <= 12'h800;
            load_q  <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            bit_q   <= bit_d;
            acc_q   <= acc_d;
            total_q <= total_d;
            load_q  <= load_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        snap_data_q <= snap_data_d;
        snap_vol_q  <= snap_vol_d;
    end

    // T0 is the IDLE cycle at count zero; held low while reset is asserted.
    assign sample_strobe = ~rst & (state_q == IDLE) & (cnt_q == '0);
    assign total_sound   = total_q;
    assign load          = load_q;
    assign en            = en_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_sound_mixer.sv
// Directed scoreboard bench for sound_mixer: expected samples are queued at stimulus
// time and compared when the DUT pulses load; control timing is checked every cycle.
module tb_sound_mixer;

    localparam int C   = 4;
    localparam int DIV = 64;
    localparam int FB  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [C*8-1:0] voice_data;
    logic [C*4-1:0] voice_vol;
    logic          mute;
    logic          sample_strobe;
    logic [11:0]   total_sound;
    logic          load;
    logic          en;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_strobe = -1;
    logic [11:0] exp_q[$];

    sound_mixer #(.CHANNELS(C), .SAMPLE_DIV(DIV), .FRAME_BITS(FB)) dut (
        .clk(clk),
        .rst(rst),
        .voice_data(voice_data),
        .voice_vol(voice_vol),
        .mute(mute),
        .sample_strobe(sample_strobe),
        .total_sound(total_sound),
        .load(load),
        .en(en),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [11:0] model(input logic [C*8-1:0] d, input logic [C*4-1:0] v, input logic m);
        int acc;
        acc = 0;
        for (int i = 0; i < C; i++)
            acc += int'($signed(d[i*8 +: 8])) * int'(v[i*4 +: 4]);
        if (acc > 2047) acc = 2047;
        if (acc < -2048) acc = -2048;
        if (m) return 12'h800;
        return 12'(acc + 2048);
    endfunction

    task automatic clear_ch();
        voice_data = '0;
        voice_vol  = '0;
    endtask

    task automatic set_ch(input int i, input logic [7:0] d, input logic [3:0] v);
        voice_data[i*8 +: 8] = d;
        voice_vol[i*4 +: 4]  = v;
    endtask

    // mode: 0 plain, 1 mute in CLIP, 2 mute in IDLE, 3 inputs change at T1, 4 reset during SHIFT
    task automatic run_frame(input int mode);
        int guard;
        int en_cnt;
        guard  = 0;
        en_cnt = 0;
        exp_q.push_back(model(voice_data, voice_vol, mode == 1));
        while (sample_strobe !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sample_strobe !== 1'b1) begin
            check("strobe_timeout", {31'd0, sample_strobe}, 32'd1);
            exp_q.delete();
            return;
        end
        for (int k = 0; k < DIV; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 0) begin
                if (last_strobe >= 0) check("strobe_period", cyc - last_strobe, DIV);
                last_strobe = cyc;
            end
            check("strobe", {31'd0, sample_strobe}, {31'd0, k == 0});
            check("load", {31'd0, load}, {31'd0, k == C + 2});
            check("en", {31'd0, en}, {31'd0, (k >= C + 3) && (k <= C + 2 + FB)});
            check("busy", {31'd0, busy}, {31'd0, (k >= 1) && (k <= C + 2 + FB)});
            if (k == C + 2) check("total_sound", {20'd0, total_sound}, {20'd0, exp_q.pop_front()});
            en_cnt += int'(en);
            if (mode == 1 && k == C + 1) mute = 1'b1;
            if (mode == 1 && k == C + 2) mute = 1'b0;
            if (mode == 2 && k == 0) mute = 1'b1;
            if (mode == 2 && k == 1) mute = 1'b0;
            if (mode == 3 && k == 1) begin
                voice_data = $urandom;
                voice_vol  = 16'($urandom);
            end
            if (mode == 4 && k == C + 6) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_en", {31'd0, en}, 32'd0);
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_load", {31'd0, load}, 32'd0);
                check("rst_strobe", {31'd0, sample_strobe}, 32'd0);
                check("rst_total", {20'd0, total_sound}, 32'h800);
                rst = 1'b0;
                #1;
                check("post_rst_strobe", {31'd0, sample_strobe}, 32'd1);
                exp_q.delete();
                last_strobe = -1;
                return;
            end
        end
        check("en_count", en_cnt, FB);
    endtask

    initial begin
        rst  = 1'b1;
        mute = 1'b0;
        clear_ch();
        repeat (3) @(negedge clk);
        check("reset_strobe", {31'd0, sample_strobe}, 32'd0);
        check("reset_load", {31'd0, load}, 32'd0);
        check("reset_en", {31'd0, en}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_total", {20'd0, total_sound}, 32'h800);
        rst = 1'b0;
        #1;

        clear_ch(); set_ch(0, 8'sd127, 4'd15);
        run_frame(0);
        clear_ch(); for (int i = 0; i < C; i++) set_ch(i, 8'sd127, 4'd15);
        run_frame(0);
        clear_ch(); for (int i = 0; i < C; i++) set_ch(i, 8'h80, 4'd15);
        run_frame(0);
        clear_ch(); set_ch(0, 8'hFF, 4'd1); set_ch(1, 8'sd1, 4'd1);
        run_frame(0);
        clear_ch(); set_ch(0, 8'hC0, 4'd8);
        run_frame(0);
        clear_ch(); set_ch(0, 8'sd127, 4'd15);
        run_frame(1);
        clear_ch(); set_ch(0, 8'sd127, 4'd15);
        run_frame(2);
        clear_ch(); set_ch(0, 8'sd100, 4'd3); set_ch(2, 8'hCE, 4'd7);
        run_frame(3);
        for (int r = 0; r < 3; r++) begin
            voice_data = $urandom;
            voice_vol  = 16'($urandom);
            run_frame(0);
        end
        clear_ch(); set_ch(0, 8'sd127, 4'd15);
        run_frame(4);
        clear_ch(); set_ch(3, 8'sd127, 4'd15); set_ch(1, 8'h80, 4'd1);
        run_frame(0);
        clear_ch(); set_ch(2, 8'sd50, 4'd2);
        run_frame(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sound_mixer.md
Name: sound_mixer

Overview:
- Mixes CHANNELS signed 8-bit voice samples, each scaled by a 4-bit volume, into one 12-bit offset-binary sample once per sample period.
- Sequences the DAC serializer's `load`/`en` controls so that one 32-bit SPI frame goes out per sample.
- Sits directly upstream of the DAC serializer and drives its `total_sound`, `load` and `en` inputs.
- Pulls fresh voice samples from the tone generators with a per-frame strobe.

Parameters:
- CHANNELS, 4: number of voices mixed; 1 to 8.
- SAMPLE_DIV, 1024: clock cycles per sample frame; must be at least CHANNELS+35.
- FRAME_BITS, 32: number of `en` cycles per SPI frame.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- voice_data  in  CHANNELS*8  packed two's-complement samples; channel i is bits [8i+7:8i].
- voice_vol  in  CHANNELS*4  packed unsigned volumes 0..15; channel i is bits [4i+3:4i].
- mute  in  1  forces a midscale output.
- sample_strobe  out  1  one-cycle pulse; voices advance to their next sample.
- total_sound  out  12  mixed unsigned offset-binary sample, to the DAC serializer.
- load  out  1  one-cycle pulse; serializer latches `total_sound`.
- en  out  1  high for FRAME_BITS consecutive cycles; serializer shifts.
- busy  out  1  high from snapshot through the last `en` cycle.

Behaviour:
- Reset values: sample_strobe=0, load=0, en=0, busy=0, total_sound=12'h800. Reset also clears the frame counter to 0, the FSM to IDLE and the accumulator to 0.
- Frame counter: runs 0..SAMPLE_DIV-1 and wraps. Cycle T0 is the cycle in which counter==0; the first T0 is the first cycle after rst falls.
- T0 (IDLE, snapshot):
  - sample_strobe=1 for exactly one cycle.
  - voice_data and voice_vol are captured into snapshot registers at the end of T0.
  - The accumulator is cleared and the FSM moves to ACCUM.
  - Input changes after T0 do not affect the current frame.
- ACCUM, cycles T1..T_CHANNELS, one channel per cycle in order 0..CHANNELS-1:
  - product = signed(sample) * unsigned(vol), 12-bit signed, range -1920..+1905.
  - acc += sign-extended product. acc is 15-bit signed; there is no overflow for CHANNELS ≤ 8.
- CLIP, cycle T_CHANNELS+1:
  - sat = clamp(acc, -2048, +2047).
  - total_sound <= sat + 2048, i.e. MSB inverted, giving 0x000..0xFFF.
  - If mute is 1 in this cycle, total_sound <= 12'h800 instead.
  - total_sound then holds until the next CLIP.
- LOAD, cycle T_CHANNELS+2: load=1 for exactly one cycle.
- SHIFT, cycles T_CHANNELS+3 .. T_CHANNELS+2+FRAME_BITS:
  - en=1 continuously, counted by a bit counter.
  - After the last en cycle the FSM returns to IDLE.
- busy: 1 from T1 through the last en cycle, otherwise 0.
- IDLE: the FSM waits for counter==0. sample_strobe, load and en are never asserted simultaneously.
- Period: exactly one strobe, one load and FRAME_BITS en cycles per SAMPLE_DIV clocks, with no drift.
- Reset mid-operation: any state aborts on the next edge. All outputs take their reset values (total_sound=12'h800) and the frame restarts from T0 after release.
- Mute: sampled only in CLIP. Toggling it elsewhere has no effect until the next frame.
- Simultaneous full-scale inputs saturate rather than wrap; clipping is symmetric at the 12-bit signed limits.

Test Plan:
- Ch0 = 8'sd127, vol 15; other channels 0 → total_sound = 0xF71 (2048+1905). Load at T_CHANNELS+2; exactly 32 en cycles; busy drops after the last en.
- All 4 channels = 127, vol 15 (acc = 7620) → 0xFFF. All 4 channels = -128, vol 15 (acc = -7680) → 0x000. Confirms saturation and no wrap.
- Ch0 = -1, vol 1; ch1 = 1, vol 1 → 0x800. Then ch0 = -64, vol 8 → 0x600 (2048-512).
- Mute high only during CLIP of a frame with ch0 = 127, vol 15 → 0x800. Mute high only in IDLE → 0xF71.
- SAMPLE_DIV=64: check strobe spacing of exactly 64 cycles over 10 frames, and that voice_data changing at T1 does not alter the current frame's result.
- Assert rst during SHIFT (en high) → next cycle en=0, busy=0, total_sound=0x800. First strobe in the first cycle after release; a clean frame follows.
